// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, bubble word and HALT decode.
package fetch_stage_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [WORD_W-1:0] NOP_WORD    = 16'h0800;
    localparam logic [4:0]        HALT_OPCODE = 5'b00000;

    function automatic logic is_halt(input logic [WORD_W-1:0] word);
        return word[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_register.sv
// Generic 16-bit register with load enable and asynchronous active-low reset.
module fetch_stage_register
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory handshake, stall buffering, redirect drain, HALT.
//   state     | meaning
//   FETCH     | request at pc, present word on ack
//   HOLD      | stalled with a buffered word, no request
//   DRAIN     | redirect seen before ack; wait for old ack, then jump to saved target
//   HALTED    | HALT consumed; fetch stopped until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] IF_instr,
    output logic [15:0] IF_PC_Next,
    output logic        IF_valid,
    output logic        halted
);

    logic [1:0]  state, state_nx;
    logic        live;
    logic [15:0] pc, pc_d, pc_inc;
    logic        pc_en;
    logic [15:0] target, target_nx;
    logic [15:0] hold_word, hold_nx;

    fetch_stage_register #(.RESET_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc)
    );

    assign pc_inc     = pc + 16'd2;
    assign imem_addr  = pc;
    assign IF_PC_Next = pc_inc;

    // live stays low until the first edge after reset release, so an ack there is ignored
    always_comb begin
        state_nx  = state;
        pc_en     = 1'b0;
        pc_d      = pc_inc;
        target_nx = target;
        hold_nx   = hold_word;
        imem_req  = 1'b0;
        IF_instr  = NOP_INSTR;
        IF_valid  = 1'b0;
        halted    = 1'b0;
        if (live) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            pc_en = 1'b1;
                            pc_d  = redirect_pc;
                        end else begin
                            target_nx = redirect_pc;
                            state_nx  = ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        IF_instr = imem_rdata;
                        IF_valid = 1'b1;
                        if (stall) begin
                            hold_nx  = imem_rdata;
                            state_nx = ST_HOLD;
                        end else begin
                            pc_en = 1'b1;
                            if (is_halt(imem_rdata)) state_nx = ST_HALTED;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_en    = 1'b1;
                        pc_d     = redirect_pc;
                        hold_nx  = NOP_INSTR;
                        state_nx = ST_FETCH;
                    end else begin
                        IF_instr = hold_word;
                        IF_valid = 1'b1;
                        if (!stall) begin
                            pc_en    = 1'b1;
                            hold_nx  = NOP_INSTR;
                            state_nx = is_halt(hold_word) ? ST_HALTED : ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_en    = 1'b1;
                        pc_d     = redirect_valid ? redirect_pc : target;
                        state_nx = ST_FETCH;
                    end else if (redirect_valid) begin
                        target_nx = redirect_pc;
                    end
                end
                ST_HALTED: halted = 1'b1;
                default:   state_nx = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            live      <= 1'b0;
            target    <= 16'h0000;
            hold_word <= NOP_INSTR;
        end else begin
            state     <= state_nx;
            live      <= 1'b1;
            target    <= target_nx;
            hold_word <= hold_nx;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [15:0] RPC = 16'h0000;
    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] IF_instr;
    logic [15:0] IF_PC_Next;
    logic        IF_valid;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IF_instr       (IF_instr),
        .IF_PC_Next     (IF_PC_Next),
        .IF_valid       (IF_valid),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rb;
        bit          st;
        bit          rv;
        logic [15:0] rpc;
        bit          ack;
        logic [15:0] rd;
        bit          e_req;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_pcn;
        bit          e_valid;
        bit          e_halted;
    } vec_t;

    vec_t tbl[$];

    // reference model: what the fetch stage is currently doing
    bit          m_live, m_held, m_drain, m_halt;
    logic [15:0] m_pc, m_hw, m_tgt;
    bit          n_held, n_drain, n_halt;
    logic [15:0] n_pc, n_hw, n_tgt;

    task automatic add(input bit rb, st, rv, input logic [15:0] rpc, input bit ack,
                       input logic [15:0] rd, input bit e_req, input logic [15:0] e_addr,
                       input logic [15:0] e_instr, input logic [15:0] e_pcn,
                       input bit e_valid, e_halted);
        vec_t v;
        v.rb = rb; v.st = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pcn = e_pcn;
        v.e_valid = e_valid; v.e_halted = e_halted;
        tbl.push_back(v);
    endtask

    // address is only meaningful while requesting; next-PC is don't-care once halted
    task automatic check(input string name, input bit e_req, input logic [15:0] e_addr,
                         input logic [15:0] e_instr, input logic [15:0] e_pcn,
                         input bit e_valid, e_halted);
        bit bad;
        n_tests++;
        bad = (imem_req !== e_req) || (e_req && imem_addr !== e_addr) ||
              (IF_instr !== e_instr) || (!e_halted && IF_PC_Next !== e_pcn) ||
              (IF_valid !== e_valid) || (halted !== e_halted);
        if (bad) begin
            n_fail++;
            $display("FAIL %s @%0t: got req=%b addr=%h instr=%h pcn=%h valid=%b halted=%b, want req=%b addr=%h instr=%h pcn=%h valid=%b halted=%b",
                     name, $time, imem_req, imem_addr, IF_instr, IF_PC_Next, IF_valid, halted,
                     e_req, e_addr, e_instr, e_pcn, e_valid, e_halted);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_held = 0; m_drain = 0; m_halt = 0;
        m_pc = RPC; m_hw = NOP; m_tgt = 16'h0000;
    endtask

    task automatic model_eval(input bit st, rv, input logic [15:0] rpc, input bit ack,
                              input logic [15:0] rd, output bit e_req,
                              output logic [15:0] e_addr, output logic [15:0] e_instr,
                              output logic [15:0] e_pcn, output bit e_valid, e_halted);
        e_req = 0; e_addr = m_pc; e_instr = NOP; e_pcn = m_pc + 16'd2; e_valid = 0; e_halted = 0;
        n_pc = m_pc; n_held = m_held; n_hw = m_hw; n_drain = m_drain; n_tgt = m_tgt; n_halt = m_halt;
        if (!m_live) begin
            // first cycle after reset release: nothing happens
        end else if (m_halt) begin
            e_halted = 1;
        end else if (m_held) begin
            if (rv) begin
                n_pc = rpc; n_held = 0;
            end else begin
                e_instr = m_hw; e_valid = 1;
                if (!st) begin
                    n_pc = m_pc + 16'd2; n_held = 0; n_halt = (m_hw[15:11] == 5'b00000);
                end
            end
        end else if (m_drain) begin
            e_req = 1;
            if (ack) begin
                n_pc = rv ? rpc : m_tgt; n_drain = 0;
            end else if (rv) begin
                n_tgt = rpc;
            end
        end else begin
            e_req = 1;
            if (rv) begin
                if (ack) n_pc = rpc;
                else begin n_drain = 1; n_tgt = rpc; end
            end else if (ack) begin
                e_instr = rd; e_valid = 1;
                if (st) begin
                    n_held = 1; n_hw = rd;
                end else begin
                    n_pc = m_pc + 16'd2; n_halt = (rd[15:11] == 5'b00000);
                end
            end
        end
    endtask

    task automatic model_commit();
        m_live = 1; m_pc = n_pc; m_held = n_held; m_hw = n_hw;
        m_drain = n_drain; m_tgt = n_tgt; m_halt = n_halt;
    endtask

    task automatic drive(input bit st, rv, input logic [15:0] rpc, input bit ack,
                         input logic [15:0] rd);
        stall = st; redirect_valid = rv; redirect_pc = rpc; imem_ack = ack; imem_rdata = rd;
    endtask

    // entered and left at posedge+1; release lands just after an edge
    task automatic do_reset(input string name);
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        check(name, 1'b0, RPC, NOP, RPC + 16'd2, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bit          st, rv, ack, e_req, e_valid, e_halted;
        logic [15:0] rpc, rd, e_addr, e_instr, e_pcn;
        int          halt_cycles;

        //   rb st rv rpc       ack rd        req addr      instr     pcn       v  h
        add(1, 0, 0, 16'h0000, 1, 16'hA001, 0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hA002, 1, 16'h0000, 16'hA002, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hA003, 1, 16'h0002, 16'hA003, 16'h0004, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hA004, 1, 16'h0004, 16'hA004, 16'h0006, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, NOP,      16'h0008, 0, 0);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'hB123, 1, 16'h0000, 16'hB123, 16'h0002, 1, 0);
        add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hB123, 16'h0002, 1, 0);
        add(0, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'hB123, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hB123, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, NOP,      16'h0004, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hC001, 1, 16'h0002, 16'hC001, 16'h0004, 1, 0);
        add(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0004, NOP,      16'h0006, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, NOP,      16'h0006, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hD00D, 1, 16'h0004, NOP,      16'h0006, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hC002, 1, 16'h0040, 16'hC002, 16'h0042, 1, 0);
        add(0, 0, 1, 16'h0080, 0, 16'h0000, 1, 16'h0042, NOP,      16'h0044, 0, 0);
        add(0, 1, 1, 16'h0090, 0, 16'h0000, 1, 16'h0042, NOP,      16'h0044, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hC003, 1, 16'h0042, NOP,      16'h0044, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0090, NOP,      16'h0092, 0, 0);
        add(0, 1, 1, 16'h0100, 1, 16'hE555, 1, 16'h0090, NOP,      16'h0092, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, NOP,      16'h0102, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'hE666, 1, 16'h0100, 16'hE666, 16'h0102, 1, 0);
        add(0, 1, 1, 16'h0200, 0, 16'h0000, 0, 16'h0100, NOP,      16'h0102, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'hE777, 1, 16'h0200, 16'hE777, 16'h0202, 1, 0);
        add(0, 0, 1, 16'hFFFE, 1, 16'h0000, 1, 16'h0202, NOP,      16'h0204, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h0000, 1, 0);
        add(0, 0, 1, 16'h0300, 1, 16'h1234, 0, 16'h0000, NOP,      16'h0000, 0, 1);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 0, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 16'h0123, 1, 16'h0000, 16'h0123, 16'h0002, 1, 0);
        add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0123, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0123, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 0, 1);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            if (tbl[i].rb) do_reset($sformatf("reset_out_row%0d", i));
            drive(tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].ack, tbl[i].rd);
            #2;
            check($sformatf("vec_row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr,
                  tbl[i].e_pcn, tbl[i].e_valid, tbl[i].e_halted);
            @(posedge clk);
            #1;
        end

        do_reset("rand_reset");
        halt_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            if (m_halt) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
                halt_cycles = 0;
            end
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = 16'($urandom) & 16'hFFFE;
            ack = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) rd = 16'($urandom) & 16'h07FF;
            else rd = {5'($urandom_range(1, 31)), 11'($urandom)};
            drive(st, rv, rpc, ack, rd);
            #2;
            model_eval(st, rv, rpc, ack, rd, e_req, e_addr, e_instr, e_pcn, e_valid, e_halted);
            check("random", e_req, e_addr, e_instr, e_pcn, e_valid, e_halted);
            @(posedge clk);
            model_commit();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800: bubble instruction driven when no valid instruction is presented.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-low.
REQ-005 Port stall, input, 1: hazard hold from decode; PC and presented instruction frozen.
REQ-006 Port redirect_valid, input, 1: taken branch/jump from a later stage.
REQ-007 Port redirect_pc, input, 16: redirect target, sampled when redirect_valid=1.
REQ-008 Port imem_req, output, 1: instruction memory request.
REQ-009 Port imem_addr, output, 16: fetch address.
REQ-010 Port imem_ack, input, 1: memory response valid; may arrive 0..N cycles after imem_req rises.
REQ-011 Port imem_rdata, input, 16: instruction word, valid when imem_ack=1.
REQ-012 Port IF_instr, output, 16: instruction to the IF/ID latch.
REQ-013 Port IF_PC_Next, output, 16: address of the presented instruction plus 2.
REQ-014 Port IF_valid, output, 1: IF_instr is a real fetched instruction, not a bubble.
REQ-015 Port halted, output, 1: HALT fetched; fetch permanently stopped.

Function
REQ-016 States are FETCH, HOLD, DRAIN and HALTED; the block SHALL leave reset in FETCH.
REQ-017 In FETCH the block SHALL drive imem_req=1 and imem_addr=pc, holding imem_addr stable until imem_ack.
REQ-018 In FETCH with imem_ack=1, stall=0 and redirect_valid=0: present imem_rdata with IF_valid=1 and IF_PC_Next=pc+2, then load pc<=pc+2.
REQ-019 In FETCH with imem_ack=1 and stall=1: buffer imem_rdata, present it with IF_valid=1, and go to HOLD; pc is unchanged.
REQ-020 In HOLD: drive imem_req=0 and present the buffered word; when stall=0, load pc<=pc+2 and go to FETCH.
REQ-021 In FETCH with no imem_ack: present NOP_INSTR with IF_valid=0 and IF_PC_Next=pc+2.
REQ-022 PC arithmetic SHALL be modulo 2^16: 16'hFFFE+2=16'h0000.
REQ-023 redirect_valid SHALL override stall and a same-cycle ack.
REQ-024 On redirect: present NOP_INSTR with IF_valid=0, discard any fetched or buffered word, and load pc<=redirect_pc.
REQ-025 On redirect in FETCH with no ack that cycle, save redirect_pc and go to DRAIN.
REQ-026 In DRAIN: keep imem_req=1 at the old address; on ack, discard the data and go to FETCH at the saved target.
REQ-027 A later redirect arriving in DRAIN SHALL replace the saved target.
REQ-028 A delivered word with bits[15:11]=5'b00000 (HALT) SHALL be presented once with IF_valid=1, after which the block goes to HALTED.
REQ-029 In HALTED: imem_req=0, NOP_INSTR, IF_valid=0, halted=1; redirect is ignored.
REQ-030 A redirect in the same cycle as HALT delivery SHALL win: no halt.
REQ-031 A stalled HALT SHALL enter HALTED only on release from HOLD.

Reset
REQ-032 On rst low, asynchronously: pc=RESET_PC, state=FETCH, saved target=0, buffer=NOP_INSTR.
REQ-033 Output reset values: imem_req=0, IF_instr=NOP_INSTR, IF_valid=0, halted=0, IF_PC_Next=RESET_PC+2.
REQ-034 Reset asserted mid-request SHALL abandon the request; any ack in the first cycle after release SHALL be ignored.

Structure
REQ-035 The state encoding, NOP_INSTR and the HALT opcode SHALL live in the shared CPU package.
REQ-036 The PC SHALL be one instance of the codebase's generic 16-bit register sub-module (register); all other logic is local.

Verification
REQ-037 Reset release, ack every cycle: imem_addr 0000, 0002, 0004; IF_PC_Next 0002, 0004, 0006; IF_valid=1 each cycle.
REQ-038 Ack on cycle 1 with stall high for 3 cycles: word held, IF_valid=1, imem_req=0, pc=0000; after release, pc=0002.
REQ-039 Redirect to 16'h0040 with a request at 0004 unacked: imem_addr stays 0004 until ack; data discarded; next imem_addr=0040.
REQ-040 Redirect to 16'h0100 together with ack and stall: bubble output (NOP_INSTR, IF_valid=0); next imem_addr=0100.
REQ-041 PC at FFFE, then fetch 16'h0000: wrap to 0000 with IF_PC_Next=0000; HALT presented once; then halted=1 and no further imem_req.
REQ-042 rst pulsed low with a request outstanding: outputs at reset values immediately; first post-reset imem_addr=RESET_PC.
